// File: rtl/led_cmd_rx.sv
// UART command receiver: frames of A5, idx, val set per-LED brightness bytes.
// Define LED_CMD_CHECKSUM_EN to require a fourth byte chk == idx ^ val.
module led_cmd_rx #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [63:0] bright,
    output logic        upd,
    output logic [3:0]  upd_idx,
    output logic        err
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_e;
    typedef enum logic [1:0] {
        P_HDR, P_IDX, P_VAL
`ifdef LED_CMD_CHECKSUM_EN
        , P_CHK
`endif
    } pstate_e;

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    warm_q, warm_d;
    logic          line_hi_q, line_hi_d;
    ustate_e       us_q, us_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    pstate_e       ps_q, ps_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [63:0]   bright_q, bright_d;
    logic          upd_q, upd_d;
    logic [3:0]    upd_idx_q, upd_idx_d;
    logic          err_q, err_d;
`ifdef LED_CMD_CHECKSUM_EN
    logic [7:0]    val_q, val_d;
`endif

    logic       rx_s, warm_done, byte_vld, frm_err, done, idx_ok, frame_ok;
    logic [7:0] wval;

    assign rx_s      = sync_q[1];
    assign warm_done = (warm_q == 2'd2);
    assign idx_ok    = (idx_q[7:3] == 5'd0) || (idx_q == 8'hFF);

    // Line must be seen high (after the synchronizer holds real samples)
    // before a low level counts as a start bit.
    always_comb begin
        sync_d    = {sync_q[0], rx};
        warm_d    = warm_done ? warm_q : warm_q + 2'd1;
        line_hi_d = line_hi_q;
        us_d      = us_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        sh_d      = sh_q;
        byte_vld  = 1'b0;
        frm_err   = 1'b0;
        unique case (us_q)
            U_IDLE: begin
                cnt_d = '0;
                if (warm_done && rx_s) line_hi_d = 1'b1;
                if (line_hi_q && !rx_s) begin
                    us_d      = U_START;
                    line_hi_d = 1'b0;
                end
            end
            U_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    us_d  = rx_s ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) us_d = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    us_d     = U_IDLE;
                    byte_vld = rx_s;
                    frm_err  = !rx_s;
                end
            end
            default: us_d = U_IDLE;
        endcase
    end

    always_comb begin
        ps_d      = ps_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        bright_d  = bright_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_d     = 1'b0;
        done      = 1'b0;
        wval      = sh_q;
        frame_ok  = idx_ok;
`ifdef LED_CMD_CHECKSUM_EN
        val_d     = val_q;
`endif
        if (frm_err) begin
            ps_d  = P_HDR;
            err_d = 1'b1;
        end else begin
            unique case (ps_q)
                P_HDR: if (byte_vld && sh_q == 8'hA5) ps_d = P_IDX;
                P_IDX: begin
                    if (byte_vld) begin
                        idx_d = sh_q;
                        ps_d  = P_VAL;
                    end
                end
`ifdef LED_CMD_CHECKSUM_EN
                P_VAL: begin
                    if (byte_vld) begin
                        val_d = sh_q;
                        ps_d  = P_CHK;
                    end
                end
                P_CHK: begin
                    if (byte_vld) begin
                        done     = 1'b1;
                        wval     = val_q;
                        frame_ok = idx_ok && (sh_q == (idx_q ^ val_q));
                        ps_d     = P_HDR;
                    end
                end
`else
                P_VAL: begin
                    if (byte_vld) begin
                        done = 1'b1;
                        ps_d = P_HDR;
                    end
                end
`endif
                default: ps_d = P_HDR;
            endcase
            if (ps_q != P_HDR && !byte_vld) begin
                if (tmo_q == TMO_M1) begin
                    ps_d  = P_HDR;
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end
        if (done) begin
            if (!frame_ok) begin
                err_d = 1'b1;
            end else if (idx_q == 8'hFF) begin
                upd_d     = 1'b1;
                bright_d  = {8{wval}};
                upd_idx_d = 4'd8;
            end else begin
                upd_d     = 1'b1;
                bright_d[{idx_q[2:0], 3'b000} +: 8] = wval;
                upd_idx_d = {1'b0, idx_q[2:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            warm_q    <= '0;
            line_hi_q <= 1'b0;
            us_q      <= U_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            ps_q      <= P_HDR;
            idx_q     <= '0;
            tmo_q     <= '0;
            bright_q  <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
`ifdef LED_CMD_CHECKSUM_EN
            val_q     <= '0;
`endif
        end else begin
            sync_q    <= sync_d;
            warm_q    <= warm_d;
            line_hi_q <= line_hi_d;
            us_q      <= us_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            ps_q      <= ps_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            bright_q  <= bright_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
`ifdef LED_CMD_CHECKSUM_EN
            val_q     <= val_d;
`endif
        end
    end

    assign bright  = bright_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_led_cmd_rx.sv
// Directed bench for led_cmd_rx with a scoreboard of expected writes.
// Honours LED_CMD_CHECKSUM_EN when defined.
module tb_led_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [63:0] bright;
    logic        upd;
    logic [3:0]  upd_idx;
    logic        err;

    always #5 clk = ~clk;

    led_cmd_rx #(
        .CLK_FREQ   (1_152_000),
        .BAUD       (115200),
        .TIMEOUT_CYC(500)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .bright (bright),
        .upd    (upd),
        .upd_idx(upd_idx),
        .err    (err)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] br;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_m;
    logic [63:0] model = '0;
    logic [63:0] prev_br;
    bit          prev_ok = 0;
    int          tests = 0;
    int          fails = 0;
    int          upd_cnt = 0;
    int          err_cnt = 0;
    int          exp_upd = 0;
    int          exp_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] i, input logic [7:0] v);
        send_byte(8'hA5);
        send_byte(i);
        send_byte(v);
`ifdef LED_CMD_CHECKSUM_EN
        send_byte(i ^ v);
`endif
    endtask

    task automatic expect_write(input logic [7:0] i, input logic [7:0] v);
        exp_t e;
        if (i == 8'hFF) begin
            model = {8{v}};
            e.idx = 4'd8;
        end else begin
            model[i[2:0]*8 +: 8] = v;
            e.idx = {1'b0, i[2:0]};
        end
        e.br = model;
        sb.push_back(e);
        exp_upd++;
    endtask

    task automatic settle(input string tag);
        repeat (40) @(negedge clk);
        chk({tag, "_upd_count"}, 64'(upd_cnt), 64'(exp_upd));
        chk({tag, "_err_count"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        chk({tag, "_bright"}, bright, model);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (upd) begin
                upd_cnt++;
                chk("upd_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e_m = sb.pop_front();
                    chk("upd_idx", 64'(upd_idx), 64'(e_m.idx));
                    chk("upd_bright", bright, e_m.br);
                end
            end
            if (err) err_cnt++;
            chk("upd_err_excl", 64'(upd && err), 64'd0);
            if (prev_ok && !upd) chk("bright_hold", bright, prev_br);
            prev_br = bright;
            prev_ok = 1;
        end else begin
            prev_ok = 0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bright", bright, 64'd0);
        chk("rst_upd", 64'(upd), 64'd0);
        chk("rst_upd_idx", 64'(upd_idx), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        expect_write(8'h03, 8'h80);
        send_frame(8'h03, 8'h80);
        settle("single");
        chk("single_value", bright, 64'h0000_0000_8000_0000);

        expect_write(8'hFF, 8'h40);
        send_frame(8'hFF, 8'h40);
        settle("bcast");
        chk("bcast_value", bright, 64'h4040_4040_4040_4040);

        exp_err++;
        send_frame(8'h09, 8'h55);
        settle("bad_idx");

        expect_write(8'h00, 8'h11);
        send_frame(8'h00, 8'h11);
        settle("after_bad_idx");

        send_byte(8'hA5);
        exp_err++;
        send_byte(8'h00, 1'b0);
        settle("framing");
        expect_write(8'h05, 8'h22);
        send_frame(8'h05, 8'h22);
        settle("after_framing");

        expect_write(8'h05, 8'h22);
        send_frame(8'h05, 8'h22);
        settle("same_value");

        expect_write(8'h02, 8'hA5);
        send_frame(8'h02, 8'hA5);
        settle("a5_as_data");

        send_byte(8'h12);
        send_byte(8'h34);
        expect_write(8'h01, 8'h7E);
        send_frame(8'h01, 8'h7E);
        settle("junk_then_frame");

`ifdef LED_CMD_CHECKSUM_EN
        exp_err++;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h5A);
        settle("bad_chk");
`endif

        send_byte(8'hA5);
        send_byte(8'h03);
        repeat (600) @(negedge clk);
        exp_err++;
        send_byte(8'h80);
        settle("timeout");

        send_byte(8'hA5);
        send_byte(8'h07);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (10) @(negedge clk);
        end
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        model = '0;
        repeat (3) @(negedge clk);
        chk("midrst_bright", bright, 64'd0);
        chk("midrst_upd", 64'(upd), 64'd0);
        chk("midrst_upd_idx", 64'(upd_idx), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        settle("post_reset_idle");

        expect_write(8'h07, 8'hFF);
        send_frame(8'h07, 8'hFF);
        settle("post_reset_frame");
        chk("post_reset_value", bright, 64'hFF00_0000_0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
